// File: rtl/ft_wr_arbiter.sv
// ft_wr_arbiter
//   Shares the single flow-table write port between the fast-path update
//   stream and the slow-path reassembly stream. Fast normally wins; a
//   starvation counter forces one slow grant after STARVE_MAX consecutive
//   fast grants taken while slow was waiting. The winner is held in a
//   one-entry registered output stage (valid/ready).
//
//   Optional feature macro: FT_ARB_STATS_EN (grant statistics counters).
//
//   Ports:
//     clk, rst_n                       clock, async active-low reset
//     f_valid/f_opcode/f_bit_map/f_data, f_ready           fast request
//     s_valid/s_opcode/s_data/s_rel_pkt_cnt, s_ready       slow request
//     w_valid/w_src/w_opcode/w_bit_map/w_data/w_rel_pkt_cnt, w_ready
//                                      flow-table write channel
//     stat_fast/stat_slow/stat_force   grant statistics (0 when disabled)
//
//   state     | meaning
//   PRIO_FAST | fast wins ties; sc counts fast grants while slow waits
//   PRIO_SLOW | sc hit STARVE_MAX; slow wins the next load cycle
module ft_wr_arbiter #(
  parameter int DWIDTH     = 512,
  parameter int BMW        = 5,
  parameter int CWIDTH     = 10,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_valid,
  input  logic [2:0]        f_opcode,
  input  logic [BMW-1:0]    f_bit_map,
  input  logic [DWIDTH-1:0] f_data,
  output logic              f_ready,
  input  logic              s_valid,
  input  logic [2:0]        s_opcode,
  input  logic [DWIDTH-1:0] s_data,
  input  logic [CWIDTH-1:0] s_rel_pkt_cnt,
  output logic              s_ready,
  output logic              w_valid,
  output logic              w_src,
  output logic [2:0]        w_opcode,
  output logic [BMW-1:0]    w_bit_map,
  output logic [DWIDTH-1:0] w_data,
  output logic [CWIDTH-1:0] w_rel_pkt_cnt,
  input  logic              w_ready,
  output logic [31:0]       stat_fast,
  output logic [31:0]       stat_slow,
  output logic [31:0]       stat_force
);

  typedef enum logic {
    PRIO_FAST = 1'b0,
    PRIO_SLOW = 1'b1
  } state_t;

  localparam logic [7:0] SC_MAX = 8'(STARVE_MAX);

  state_t     state;
  logic [7:0] sc;
  logic [7:0] sc_inc;
  logic       load;
  logic       grant_f;
  logic       grant_s;

  assign load   = !w_valid || w_ready;
  assign sc_inc = sc + 8'd1;

  always_comb begin
    grant_f = 1'b0;
    grant_s = 1'b0;
    if (load) begin
      if (state == PRIO_SLOW) begin
        grant_s = s_valid;
        grant_f = f_valid && !s_valid;
      end else begin
        grant_f = f_valid;
        grant_s = s_valid && !f_valid;
      end
    end
  end

  assign f_ready = grant_f;
  assign s_ready = grant_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= PRIO_FAST;
      sc            <= 8'd0;
      w_valid       <= 1'b0;
      w_src         <= 1'b0;
      w_opcode      <= 3'd0;
      w_bit_map     <= '0;
      w_data        <= '0;
      w_rel_pkt_cnt <= '0;
    end else if (load) begin
      // Stall (w_valid && !w_ready) skips this branch: output, sc and state freeze.
      w_valid <= grant_f || grant_s;
      if (grant_f) begin
        w_src         <= 1'b0;
        w_opcode      <= f_opcode;
        w_bit_map     <= f_bit_map;
        w_data        <= f_data;
        w_rel_pkt_cnt <= '0;
      end else if (grant_s) begin
        w_src         <= 1'b1;
        w_opcode      <= s_opcode;
        w_bit_map     <= '0;
        w_data        <= s_data;
        w_rel_pkt_cnt <= s_rel_pkt_cnt;
      end
      if (!s_valid || grant_s) begin
        sc    <= 8'd0;
        state <= PRIO_FAST;
      end else if (grant_f) begin
        // Only reachable in PRIO_FAST (slow is waiting), so sc never passes SC_MAX.
        sc <= sc_inc;
        if (sc_inc == SC_MAX) state <= PRIO_SLOW;
      end
    end
  end

`ifdef FT_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fast  <= 32'd0;
      stat_slow  <= 32'd0;
      stat_force <= 32'd0;
    end else begin
      if (grant_f) stat_fast <= stat_fast + 32'd1;
      if (grant_s) stat_slow <= stat_slow + 32'd1;
      if (grant_s && state == PRIO_SLOW && f_valid) stat_force <= stat_force + 32'd1;
    end
  end
`else
  assign stat_fast  = 32'd0;
  assign stat_slow  = 32'd0;
  assign stat_force = 32'd0;
`endif

endmodule

// File: doc/ft_wr_arbiter.md
# ft_wr_arbiter

Shares the single flow-table write port between the fast-path update stream (in-order insert/update/delete decisions) and the slow-path reassembly stream (OOO linked-list writes and slow_cnt releases). It sits between those two producers and the flow table write channel. Fast path normally wins. A starvation guard forces one slow grant after a bounded run of fast grants. The winning request is held in a one-entry registered output stage with a valid/ready handshake.

## Interface
- DWIDTH, 512: width of a flow-cache entry (fce) word.
- BMW, 5: sub-table bit_map width; bit BMW-1 selects the parallel insert queue.
- CWIDTH, 10: width of the slow-path released-packet count.
- STARVE_MAX, 8: consecutive fast grants allowed while slow is pending; range 1..255.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- f_valid  in  1  fast request valid.
- f_opcode  in  3  FT_INSERT / FT_UPDATE / FT_DELETE.
- f_bit_map  in  BMW  target sub-table map.
- f_data  in  DWIDTH  fce to write.
- f_ready  out  1  fast request accepted this cycle.
- s_valid  in  1  slow request valid.
- s_opcode  in  3  slow opcode.
- s_data  in  DWIDTH  fce to write.
- s_rel_pkt_cnt  in  CWIDTH  packets released by reassembly.
- s_ready  out  1  slow request accepted this cycle.
- w_valid  out  1  write to flow table valid.
- w_src  out  1  0 = fast, 1 = slow.
- w_opcode, w_bit_map, w_data, w_rel_pkt_cnt  out  3/BMW/DWIDTH/CWIDTH  granted request fields.
- w_ready  in  1  flow table accepts the write.
- stat_fast, stat_slow, stat_force  out  32 each  statistics, see Configuration.

## Operation
- Load condition: `load = !w_valid | w_ready`. At most one input is accepted per cycle, and only when load = 1.
- State PRIO_FAST:
  - grant fast if f_valid;
  - otherwise grant slow if s_valid.
- State PRIO_SLOW:
  - grant slow if s_valid;
  - otherwise grant fast if f_valid.
- Starvation counter `sc` (8 bits):
  - Increment on a fast grant while s_valid = 1.
  - Clear on any slow grant.
  - Clear when s_valid = 0.
  - When it reaches STARVE_MAX, move to PRIO_SLOW (no further increment).
- Leaving PRIO_SLOW:
  - return to PRIO_FAST on a slow grant;
  - also return to PRIO_FAST if s_valid = 0 (with sc cleared).
- Output field rules:
  - Slow grant: w_bit_map = 0.
  - Fast grant: w_rel_pkt_cnt = 0.
  - Other fields are copied from the winner.
- Requesters must hold valid and fields stable until ready. The block does not check this.
- No grant but load = 1: w_valid goes to 0 and the output fields keep their old values.

## Timing
- Latency: request accepted at edge N appears on w_* after edge N (registered output).
- f_ready and s_ready are combinational from the valids, state, sc and w_ready. They are never both 1.
- Full throughput is 1 write/cycle while w_ready = 1.
- Back-pressure (w_valid = 1, w_ready = 0):
  - the output holds stable;
  - f_ready = s_ready = 0;
  - sc and state are frozen.
- Reset (asynchronous, at any time, including mid-transfer):
  - w_valid = 0, w_src = 0, w_opcode = 0, w_bit_map = 0, w_data = 0, w_rel_pkt_cnt = 0;
  - state = PRIO_FAST, sc = 0, all stat_* = 0.
  - An in-flight output word is discarded.
- Simultaneous events: f_valid and s_valid in the same cycle resolve by state, as above. A forced slow grant happens on the first load cycle after sc hits STARVE_MAX.
- STARVE_MAX = 1 yields strict fast/slow alternation while both request.

## Configuration
- FT_ARB_STATS_EN defined:
  - stat_fast increments per fast grant;
  - stat_slow increments per slow grant;
  - stat_force increments per slow grant made in PRIO_SLOW while f_valid = 1.
  - All three are 32-bit and wrap at 2^32.
- FT_ARB_STATS_EN undefined: stat_* are tied to 0 and no counter logic is built. Arbitration behaviour is identical in both cases.

## Test plan
- Fast only: f_valid = 1 for 20 cycles, w_ready = 1 → 20 writes, w_src = 0 each cycle, latency 1, s_ready never 1.
- Both requesting, STARVE_MAX = 8, w_ready = 1 → grant pattern of 8 fast, 1 slow, repeating. With stats enabled, stat_force = 1 per 9 writes.
- Slow only, s_rel_pkt_cnt = 3 → w_src = 1, w_rel_pkt_cnt = 3, w_bit_map = 0.
- Back-pressure: w_ready = 0 for 5 cycles with both valid → w_* stable, both readys 0, sc unchanged. Release → next grant follows the pre-stall state.
- s_valid drops while in PRIO_SLOW → state returns to PRIO_FAST, sc = 0, next grant goes to fast.
- rst_n asserted asynchronously mid-stream with w_valid = 1 → w_valid = 0 immediately, state PRIO_FAST, stat_* = 0. After release, the first grant goes to fast when both are valid.
